// File: rtl/module_lpf_biquad_if.sv
// Signal bundle tying the biquad to its coefficient calculator, the sample stream and its DSP slice.
// The filter side uses the master modport; the environment (calculator, source, DSP) uses slave.
interface module_lpf_biquad_if;
  logic [17:0] omega0;
  logic [17:0] inv_2Q;
  logic [17:0] calc_omega0;
  logic [17:0] calc_inv_2Q;
  logic        do_calc;
  logic        calc_done;
  logic [89:0] coefs_flat;
  logic [17:0] sample_in;
  logic        sample_in_valid;
  logic        sample_in_ready;
  logic [17:0] sample_out;
  logic        sample_out_valid;
  logic [43:0] dsp_ins_flat;
  logic [83:0] dsp_outs_flat;

  modport master (
    input  omega0, inv_2Q, calc_done, coefs_flat, sample_in, sample_in_valid, dsp_outs_flat,
    output calc_omega0, calc_inv_2Q, do_calc, sample_in_ready, sample_out, sample_out_valid,
           dsp_ins_flat
  );

  modport slave (
    output omega0, inv_2Q, calc_done, coefs_flat, sample_in, sample_in_valid, dsp_outs_flat,
    input  calc_omega0, calc_inv_2Q, do_calc, sample_in_ready, sample_out, sample_out_valid,
           dsp_ins_flat
  );
endinterface

// File: rtl/module_lpf_biquad.sv
// Direct-Form-I biquad low-pass filter that time-shares an external DSP48A1 slice and
// keeps its coefficients fresh by requesting them from the calculator on parameter changes.
module module_lpf_biquad (
  input  logic                clk,
  input  logic                reset,
  module_lpf_biquad_if.master bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_WAIT, ST_OUT} state_e;

  localparam logic [89:0] PassthroughCoefs = {72'h0, 18'h10000};
  localparam logic [7:0]  OpLoad = 8'h01;
  localparam logic [7:0]  OpAdd  = 8'h09;
  localparam logic [7:0]  OpSub  = 8'h89;

  state_e      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [17:0] x_q, x1_q, x2_q, y1_q, y2_q;
  logic [89:0] coef_q, shadow_q;
  logic        shadowValid_q;
  logic [17:0] out_q;
  logic        outValid_q;
  logic        reqPending_q, outstanding_q, doCalc_q;
  logic [17:0] calcOmega_q, calcInv_q;

  logic        idle, copyShadow, accept, loadOut;
  logic        calcDone, paramsChanged, wantReq, issue;
  logic [47:0] p;
  logic        overflow;
  logic [17:0] ySat;
  logic [43:0] dspIns;
  logic        unusedDsp;

  assign p         = bus.dsp_outs_flat[47:0];
  assign unusedDsp = ^{bus.dsp_outs_flat[83:48], p[15:0]};
  assign overflow  = ~((&p[47:33]) | ~(|p[47:33]));
  assign ySat      = overflow ? (p[47] ? 18'h20000 : 18'h1FFFF) : p[33:16];

  assign idle       = (state_q == ST_IDLE);
  assign copyShadow = idle & shadowValid_q;
  assign accept     = idle & ~shadowValid_q & bus.sample_in_valid;
  // p is final during the last WAIT cycle, so the result is registered then and is visible in OUT.
  assign loadOut    = (state_q == ST_WAIT) & (k_q == 3'd1);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    dspIns  = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_MAC;
          k_d     = 3'd0;
        end
      end
      ST_MAC: begin
        case (k_q)
          3'd0:    dspIns = {OpLoad, x_q,  coef_q[17:0]};
          3'd1:    dspIns = {OpAdd,  x1_q, coef_q[35:18]};
          3'd2:    dspIns = {OpAdd,  x2_q, coef_q[53:36]};
          3'd3:    dspIns = {OpSub,  y1_q, coef_q[71:54]};
          3'd4:    dspIns = {OpSub,  y2_q, coef_q[89:72]};
          default: dspIns = '0;
        endcase
        if (k_q == 3'd4) begin
          state_d = ST_WAIT;
          k_d     = 3'd0;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      ST_WAIT: begin
        if (k_q == 3'd1) begin
          state_d = ST_OUT;
          k_d     = 3'd0;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      ST_OUT: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      k_q           <= 3'd0;
      x_q           <= '0;
      x1_q          <= '0;
      x2_q          <= '0;
      y1_q          <= '0;
      y2_q          <= '0;
      out_q         <= '0;
      outValid_q    <= 1'b0;
      coef_q        <= PassthroughCoefs;
      shadow_q      <= PassthroughCoefs;
      shadowValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      outValid_q <= loadOut;
      if (accept) x_q <= bus.sample_in;
      if (loadOut) begin
        out_q <= ySat;
        x2_q  <= x1_q;
        x1_q  <= x_q;
        y2_q  <= y1_q;
        y1_q  <= ySat;
      end
      if (copyShadow) coef_q <= shadow_q;
      if (calcDone) shadow_q <= bus.coefs_flat;
      shadowValid_q <= calcDone | (shadowValid_q & ~copyShadow);
    end
  end

  // A finishing request may hand over straight to a pending one in the same cycle.
  assign calcDone      = bus.calc_done & outstanding_q;
  assign paramsChanged = (bus.omega0 != calcOmega_q) | (bus.inv_2Q != calcInv_q);
  assign wantReq       = reqPending_q | paramsChanged;
  assign issue         = wantReq & (~outstanding_q | calcDone);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reqPending_q  <= 1'b1;
      outstanding_q <= 1'b0;
      doCalc_q      <= 1'b0;
      calcOmega_q   <= '0;
      calcInv_q     <= '0;
    end else begin
      doCalc_q      <= issue;
      outstanding_q <= issue | (outstanding_q & ~calcDone);
      reqPending_q  <= wantReq & ~issue;
      if (issue) begin
        calcOmega_q <= bus.omega0;
        calcInv_q   <= bus.inv_2Q;
      end
    end
  end

  assign bus.calc_omega0      = calcOmega_q;
  assign bus.calc_inv_2Q      = calcInv_q;
  assign bus.do_calc          = doCalc_q;
  assign bus.sample_in_ready  = idle & ~shadowValid_q & ~reset;
  assign bus.sample_out       = out_q;
  assign bus.sample_out_valid = outValid_q;
  assign bus.dsp_ins_flat     = dspIns;
endmodule

// File: tb/tb_module_lpf_biquad.sv
// Self-checking bench for module_lpf_biquad: models the DSP48A1 slice and the calculator,
// and predicts every filtered sample with a plain-arithmetic difference-equation model.
module tb_module_lpf_biquad;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  module_lpf_biquad_if bus();
  module_lpf_biquad dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;
  int doCalcCount = 0;
  int lastDoCalcCycle = -1;
  logic [17:0] lastCalcOmega = '0;

  // DSP48A1 behaviour: operands registered, then P = Z +/- X one cycle later (t -> t+2).
  logic [43:0]        dspStage = '0;
  logic signed [47:0] dspP = '0;
  logic signed [35:0] dspM;
  logic signed [47:0] dspX, dspZ;
  assign dspM = $signed(dspStage[35:18]) * $signed(dspStage[17:0]);
  assign dspX = (dspStage[37:36] == 2'b01) ? {{12{dspM[35]}}, dspM} : 48'sd0;
  assign dspZ = (dspStage[39:38] == 2'b10) ? dspP : 48'sd0;
  assign bus.dsp_outs_flat = {dspM, dspP};
  always @(posedge clk) begin
    dspStage <= bus.dsp_ins_flat;
    dspP     <= dspStage[43] ? (dspZ - dspX) : (dspZ + dspX);
  end

  always @(posedge clk) cycleCnt <= cycleCnt + 1;
  always @(negedge clk) begin
    if (bus.do_calc === 1'b1) begin
      doCalcCount     <= doCalcCount + 1;
      lastDoCalcCycle <= cycleCnt;
      lastCalcOmega   <= bus.calc_omega0;
    end
  end

  longint mB0, mB1, mB2, mA1, mA2, mX1, mX2, mY1, mY2;

  function automatic longint sx(input logic [17:0] v);
    return longint'($signed(v));
  endfunction

  task automatic setModelCoefs(input logic [89:0] c);
    mB0 = sx(c[17:0]);  mB1 = sx(c[35:18]); mB2 = sx(c[53:36]);
    mA1 = sx(c[71:54]); mA2 = sx(c[89:72]);
  endtask

  task automatic modelReset();
    mX1 = 0; mX2 = 0; mY1 = 0; mY2 = 0;
    setModelCoefs({72'h0, 18'h10000});
  endtask

  // y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2 in Q3.33, rescaled to Q1.17 and clamped.
  task automatic modelStep(input logic [17:0] x, output logic [17:0] y);
    longint acc, q;
    acc = mB0 * sx(x) + mB1 * mX1 + mB2 * mX2 - mA1 * mY1 - mA2 * mY2;
    q = acc >>> 16;
    if (q > 131071) q = 131071;
    else if (q < -131072) q = -131072;
    y = q[17:0];
    mX2 = mX1; mX1 = sx(x); mY2 = mY1; mY1 = q;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    bus.sample_in_valid = 1'b0;
    bus.calc_done = 1'b0;
    repeat (2) @(negedge clk);
    modelReset();
    reset = 1'b0;
  endtask

  task automatic runSample(input logic [17:0] x, output logic [17:0] y, output int lat);
    @(negedge clk);
    bus.sample_in = x;
    bus.sample_in_valid = 1'b1;
    for (int n = 0; n < 30 && bus.sample_in_ready !== 1'b1; n++) @(negedge clk);
    @(posedge clk);
    #1;
    bus.sample_in_valid = 1'b0;
    y = 'x;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus.sample_out_valid === 1'b1) begin
        y = bus.sample_out;
        lat = n;
        break;
      end
    end
  endtask

  task automatic waitDoCalc(output int cyc, output logic [17:0] om);
    cyc = -1;
    om = 'x;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus.do_calc === 1'b1) begin
        cyc = cycleCnt;
        om = bus.calc_omega0;
        break;
      end
    end
  endtask

  task automatic respond(input logic [89:0] c, output int doneCyc);
    @(negedge clk);
    bus.coefs_flat = c;
    bus.calc_done = 1'b1;
    doneCyc = cycleCnt;
    @(negedge clk);
    bus.calc_done = 1'b0;
  endtask

  task automatic loadCoefs(input logic [17:0] newOmega, input logic [89:0] c);
    int cyc, dc;
    logic [17:0] om;
    @(negedge clk);
    bus.omega0 = newOmega;
    waitDoCalc(cyc, om);
    repeat (3) @(negedge clk);
    respond(c, dc);
    repeat (3) @(negedge clk);
    setModelCoefs(c);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus.sample_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b want 0", bus.sample_in_ready); end
    checks++; if (bus.do_calc !== 1'b0) begin errors++; $display("[TB] FAIL reset_do_calc got %b want 0", bus.do_calc); end
    checks++; if (bus.sample_out !== 18'h0) begin errors++; $display("[TB] FAIL reset_sample_out got %h want 0", bus.sample_out); end
    checks++; if (bus.sample_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", bus.sample_out_valid); end
    checks++; if (bus.dsp_ins_flat !== 44'h0) begin errors++; $display("[TB] FAIL reset_dsp_ins got %h want 0", bus.dsp_ins_flat); end
    checks++; if (bus.calc_omega0 !== 18'h0 || bus.calc_inv_2Q !== 18'h0) begin errors++; $display("[TB] FAIL reset_calc_params got %h/%h want 0/0", bus.calc_omega0, bus.calc_inv_2Q); end
    modelReset();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.do_calc !== 1'b1) begin errors++; $display("[TB] FAIL first_do_calc got %b want 1", bus.do_calc); end
  endtask

  task automatic test_passthrough();
    logic [17:0] y, ym;
    int lat;
    runSample(18'h08000, y, lat);
    modelStep(18'h08000, ym);
    checks++; if (y !== 18'h08000) begin errors++; $display("[TB] FAIL passthrough_value got %h want 08000", y); end
    checks++; if (lat != 8) begin errors++; $display("[TB] FAIL passthrough_latency got %0d want 8", lat); end
    @(negedge clk);
    checks++; if (bus.sample_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL out_valid_pulse got %b want 0", bus.sample_out_valid); end
    checks++; if (bus.dsp_ins_flat !== 44'h0) begin errors++; $display("[TB] FAIL idle_dsp_ins got %h want 0", bus.dsp_ins_flat); end
  endtask

  task automatic test_request_handshake();
    int cyc, dc, base, lat;
    logic [17:0] om, y, ym;
    logic [89:0] c;
    c = {72'h0, 18'h04000};
    bus.omega0 = 18'h01000;
    applyReset();
    #1 base = doCalcCount;
    waitDoCalc(cyc, om);
    checks++; if (om !== 18'h01000) begin errors++; $display("[TB] FAIL handshake_calc_omega0 got %h want 01000", om); end
    repeat (19) @(negedge clk);
    checks++; if (bus.calc_omega0 !== 18'h01000) begin errors++; $display("[TB] FAIL calc_omega0_stable got %h want 01000", bus.calc_omega0); end
    respond(c, dc);
    setModelCoefs(c);
    repeat (5) @(negedge clk);
    #1;
    checks++; if (doCalcCount - base != 1) begin errors++; $display("[TB] FAIL handshake_do_calc_count got %0d want 1", doCalcCount - base); end
    runSample(18'h10000, y, lat);
    modelStep(18'h10000, ym);
    checks++; if (y !== 18'h04000) begin errors++; $display("[TB] FAIL handshake_scaled got %h want 04000", y); end
  endtask

  task automatic test_saturation();
    logic [17:0] y, ym;
    int lat;
    loadCoefs(18'h02000, {72'h0, 18'h1FFFF});
    runSample(18'h1FFFF, y, lat);
    modelStep(18'h1FFFF, ym);
    checks++; if (y !== 18'h1FFFF) begin errors++; $display("[TB] FAIL sat_positive got %h want 1ffff", y); end
    runSample(18'h20000, y, lat);
    modelStep(18'h20000, ym);
    checks++; if (y !== 18'h20000) begin errors++; $display("[TB] FAIL sat_negative got %h want 20000", y); end
  endtask

  task automatic test_recursion();
    logic [17:0] xs[3], want[3];
    logic [17:0] y, ym, om;
    logic [89:0] c;
    int lat, cyc, dc;
    xs = '{18'h10000, 18'h0, 18'h0};
    want = '{18'h10000, 18'h08000, 18'h04000};
    c = {18'h0, 18'h38000, 18'h0, 18'h0, 18'h10000};
    applyReset();
    waitDoCalc(cyc, om);
    respond(c, dc);
    setModelCoefs(c);
    for (int i = 0; i < 3; i++) begin
      runSample(xs[i], y, lat);
      modelStep(xs[i], ym);
      checks++; if (y !== want[i]) begin errors++; $display("[TB] FAIL recursion_%0d got %h want %h", i, y, want[i]); end
    end
  endtask

  task automatic test_ignored_done();
    int base, dc, lat;
    logic [17:0] y, ym;
    #1 base = doCalcCount;
    respond({5{18'h1FFFF}}, dc);
    repeat (3) @(negedge clk);
    runSample(18'h0, y, lat);
    modelStep(18'h0, ym);
    checks++; if (y !== 18'h02000) begin errors++; $display("[TB] FAIL stray_done_ignored got %h want 02000", y); end
    #1;
    checks++; if (doCalcCount != base) begin errors++; $display("[TB] FAIL stray_done_no_request got %0d want %0d", doCalcCount, base); end
  endtask

  task automatic test_busy_update();
    int cyc, dc, lat1, lat2;
    logic [17:0] om, y1, y2, ym1, ym2;
    logic [89:0] c;
    c = {72'h0, 18'h08000};
    @(negedge clk);
    bus.omega0 = 18'h03000;
    waitDoCalc(cyc, om);
    fork
      runSample(18'h0C000, y1, lat1);
      begin
        repeat (3) @(negedge clk);
        respond(c, dc);
      end
    join
    modelStep(18'h0C000, ym1);
    checks++; if (y1 !== ym1) begin errors++; $display("[TB] FAIL busy_old_coefs got %h want %h", y1, ym1); end
    setModelCoefs(c);
    runSample(18'h0C000, y2, lat2);
    modelStep(18'h0C000, ym2);
    checks++; if (y2 !== ym2) begin errors++; $display("[TB] FAIL busy_new_coefs got %h want %h", y2, ym2); end
  endtask

  task automatic test_change_outstanding();
    int cyc, dc, dc2, base;
    logic [17:0] om;
    logic [89:0] c;
    c = {72'h0, 18'h10000};
    @(negedge clk);
    bus.omega0 = 18'h05000;
    waitDoCalc(cyc, om);
    #1 base = doCalcCount;
    checks++; if (om !== 18'h05000) begin errors++; $display("[TB] FAIL outstanding_first got %h want 05000", om); end
    repeat (3) @(negedge clk);
    bus.omega0 = 18'h06000;
    repeat (3) @(negedge clk);
    bus.omega0 = 18'h07000;
    repeat (3) @(negedge clk);
    respond(c, dc);
    setModelCoefs(c);
    repeat (10) @(negedge clk);
    #1;
    checks++; if (doCalcCount - base != 1) begin errors++; $display("[TB] FAIL outstanding_count got %0d want 1", doCalcCount - base); end
    checks++; if (lastDoCalcCycle != dc + 1) begin errors++; $display("[TB] FAIL outstanding_timing got %0d want %0d", lastDoCalcCycle, dc + 1); end
    checks++; if (lastCalcOmega !== 18'h07000) begin errors++; $display("[TB] FAIL outstanding_latest got %h want 07000", lastCalcOmega); end
    respond(c, dc2);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    logic [89:0] c;
    logic [17:0] x, y, ym;
    int lat;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) c[i*18 +: 18] = 18'($urandom_range(0, 98304)) - 18'd49152;
      loadCoefs(18'h08000 + 18'(r), c);
      for (int s = 0; s < 5; s++) begin
        x = 18'($urandom);
        runSample(x, y, lat);
        modelStep(x, ym);
        checks++; if (y !== ym || lat != 8) begin errors++; $display("[TB] FAIL random_r%0d_s%0d got %h lat %0d want %h lat 8", r, s, y, lat, ym); end
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [17:0] y, ym;
    int lat, seen;
    @(negedge clk);
    bus.sample_in = 18'h0A000;
    bus.sample_in_valid = 1'b1;
    @(posedge clk);
    #1 bus.sample_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.dsp_ins_flat !== 44'h0 || bus.sample_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_outputs got %h/%b want 0/0", bus.dsp_ins_flat, bus.sample_out_valid); end
    bus.coefs_flat = {5{18'h1FFFF}};
    bus.calc_done = 1'b1;
    modelReset();
    reset = 1'b0;
    @(negedge clk);
    bus.calc_done = 1'b0;
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (bus.sample_out_valid === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("[TB] FAIL abort_no_output got %0d want 0", seen); end
    runSample(18'h0C000, y, lat);
    modelStep(18'h0C000, ym);
    checks++; if (y !== 18'h0C000) begin errors++; $display("[TB] FAIL late_done_ignored got %h want 0c000", y); end
  endtask

  initial begin
    bus.omega0 = '0;
    bus.inv_2Q = '0;
    bus.calc_done = 1'b0;
    bus.coefs_flat = '0;
    bus.sample_in = '0;
    bus.sample_in_valid = 1'b0;
    test_reset();
    test_passthrough();
    test_request_handshake();
    test_saturation();
    test_recursion();
    test_ignored_done();
    test_busy_update();
    test_change_outstanding();
    test_random();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end
endmodule

// File: doc/module_lpf_biquad.md
# module_lpf_biquad

Sample-domain low-pass filter that consumes the coefficient calculator's output. Acts as the initiator on the `do_calc` / `calc_done` / `coefs_flat` handshake:
- requests new coefficients whenever `omega0` or `inv_2Q` changes;
- latches the result and applies it atomically at a sample boundary;
- runs a Direct-Form-I biquad through its own DSP48A1 slice, using the flat DSP port format.

## Interface
- No parameters.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `omega0` in 18: signed, requested cutoff parameter, forwarded to the calculator.
- `inv_2Q` in 18: signed, requested 1/(2Q), forwarded to the calculator.
- `calc_omega0` out 18: registered copy of `omega0` sent with the request. Stable from `do_calc` until `calc_done`.
- `calc_inv_2Q` out 18: registered copy of `inv_2Q`, same rule as `calc_omega0`.
- `do_calc` out 1: one-cycle coefficient request pulse.
- `calc_done` in 1: one-cycle pulse from the calculator. `coefs_flat` is valid in the same cycle.
- `coefs_flat` in 90: 5×18-bit signed Q2.16 coefficients.
  - `[17:0]` b0, `[35:18]` b1, `[53:36]` b2, `[71:54]` a1, `[89:72]` a2.
- `sample_in` in 18: signed Q1.17 input sample.
- `sample_in_valid` in 1: input strobe. Accepted only when `sample_in_ready` is high.
- `sample_in_ready` out 1: high in IDLE only.
- `sample_out` out 18: signed Q1.17 filtered sample.
- `sample_out_valid` out 1: one-cycle strobe marking `sample_out` new.
- `dsp_ins_flat` out 44: `{opmode[7:0], a[17:0], b[17:0]}` to the DSP.
- `dsp_outs_flat` in 84: `{m[35:0], p[47:0]}` from the DSP.

## Operation
- Filter equation: y = b0·x + b1·x1 + b2·x2 − a1·y1 − a2·y2.
- History registers x1, x2, y1, y2 hold 18-bit values.
- FSM states:
  - **IDLE**: `sample_in_ready` = 1. `sample_in_valid` latches x and moves to MAC with counter k = 0.
  - **MAC**: k = 0..4. One DSP op per cycle; a = sample/history, b = coefficient.
    - k=0: (x, b0), opmode 8'h01 (P = M).
    - k=1: (x1, b1), opmode 8'h09 (P = P + M).
    - k=2: (x2, b2), opmode 8'h09.
    - k=3: (y1, a1), opmode 8'h89 (P = P − M).
    - k=4: (y2, a2), opmode 8'h89.
    - After k=4, go to WAIT.
  - **WAIT**: 2 cycles for DSP latency. `opmode` = 8'h00; a and b = 0.
  - **OUT**:
    - y = sat18(p[33:16]). Saturate to 18'h1FFFF / 18'h20000 when p[47:33] is not all equal to p[47].
    - Register y to `sample_out`; pulse `sample_out_valid`.
    - Shift history: x2←x1, x1←x, y2←y1, y1←y (saturated y).
    - Return to IDLE.
- Outside MAC, `dsp_ins_flat` = 44'h0.
- Active coefficient set:
  - Reset value is passthrough: b0 = 18'h10000 (1.0), all others 0.
  - Changes only in IDLE, never during MAC/WAIT/OUT.
- Coefficient request controller:
  - `req_pending` is set when (`omega0`, `inv_2Q`) ≠ last-requested pair, and also after reset.
  - `do_calc` is pulsed when `req_pending` is set and no request is outstanding. This is independent of filter state.
  - On that pulse, latch `calc_omega0` / `calc_inv_2Q` and set `outstanding`.
  - Only one request may be outstanding. Parameter changes during an outstanding request set `req_pending`; the new request is issued the cycle after `calc_done`.
  - On `calc_done`: capture `coefs_flat` into a shadow register, set `shadow_valid`, clear `outstanding`.
  - Shadow→active copy happens in IDLE when `shadow_valid` is set; clear `shadow_valid` at the copy.
  - `calc_done` while not outstanding is ignored.
- Simultaneous events:
  - Shadow copy takes priority over sample acceptance in the same IDLE cycle.
  - `sample_in_ready` is 0 during the copy cycle.
- History is not cleared on a coefficient change.

## Timing
- Reset values:
  - `do_calc` 0, `sample_in_ready` 0 during reset, `sample_out` 0, `sample_out_valid` 0, `dsp_ins_flat` 0.
  - `calc_omega0` and `calc_inv_2Q` 0.
  - History 0; active coefficients passthrough; FSM IDLE; `req_pending` 1.
- Async reset mid-operation aborts the sample and any outstanding request. A `calc_done` arriving after reset deassertion is ignored.
- DSP contract: inputs presented in cycle t give p at cycle t+2. Back-to-back accumulate ops chain inside the DSP.
- Sample latency: accept at cycle 0; MAC cycles 1–5; WAIT 6–7; `sample_out_valid` at cycle 8.
- Minimum input period is 9 cycles.
- First `do_calc` occurs on the first clock after reset deassertion.

## Test plan
- **Passthrough**: hold `calc_done` low after reset; `sample_in` = 18'h08000 → `sample_out` = 18'h08000 with `sample_out_valid` at cycle 8.
- **Request handshake**: `omega0` = 18'h01000 → exactly one `do_calc` with `calc_omega0` = 18'h01000. Responder returns `calc_done` 20 cycles later with b0 = 18'h04000 (0.25), others 0. Next sample 18'h10000 → `sample_out` = 18'h04000.
- **Saturation**:
  - b0 = 18'h1FFFF, x = 18'h1FFFF → 18'h1FFFF.
  - b0 = 18'h1FFFF, x = 18'h20000 → 18'h20000.
- **Recursion**: b0 = 18'h10000, a1 = 18'h38000 (−0.5), impulse 18'h10000 then zeros → outputs 18'h10000, 18'h08000, 18'h04000.
- **Busy update**: `calc_done` arrives during MAC → the current sample uses the old coefficients and the next sample uses the new ones.
- **Change while outstanding**: change `omega0` twice during one request → exactly one further `do_calc`, issued one cycle after `calc_done`, carrying the latest value.
